network_ejection_vc_arbiter: RTL
================================

Name: network_ejection_vc_arbiter

Overview:
Shares the single local ejection port of a router between NUM_VC virtual-channel ejection queues. It uses packet-level (wormhole) round-robin arbitration: once a header flit wins, that VC owns the port until its tail flit leaves. The output is registered with valid/ready on both sides, and the block sits between the router's per-VC ejection buffers and the network ejector/endpoint interface.

Parameters:
NUM_VC, 4, number of virtual-channel inputs (≥2).
FLIT_WIDTH, 64, flit payload width in bits.
VC_ID_WIDTH, $clog2(NUM_VC), width of the VC identifier.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  synchronous active-low reset.
flit_i  input  NUM_VC*FLIT_WIDTH  per-VC flit; VC k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH].
flit_type_i  input  NUM_VC*2  per-VC flit type: 00 header, 01 body, 10 tail, 11 header_tail.
valid_i  input  NUM_VC  per-VC flit valid.
ready_o  output  NUM_VC  per-VC accept; at most one bit is high per cycle.
flit_o  output  FLIT_WIDTH  ejected flit (registered).
flit_type_o  output  2  type of the ejected flit.
vc_id_o  output  VC_ID_WIDTH  source VC of the ejected flit.
valid_o  output  1  output flit valid.
ready_i  input  1  downstream accept.
error_o  output  1  sticky protocol-error flag.
pkt_count_o  output  32  count of packets completed (tail or header_tail transferred out).

Behaviour:
- Reset (rst_ni=0 at a clock edge): valid_o=0; flit_o, flit_type_o, vc_id_o=0; ready_o=0; error_o=0; pkt_count_o=0; state=IDLE; RR pointer=0; lock owner=0. Reset mid-packet discards the packet in flight and the output register contents.
- Input transfer on VC k: valid_i[k] && ready_o[k]. Output transfer: valid_o && ready_i.
- Output register load enable: load_en = !valid_o || ready_i. ready_o is all-zero whenever load_en=0.
- A transferred flit appears on flit_o, flit_type_o and vc_id_o in the next cycle with valid_o=1. Latency is 1 cycle. Full throughput is 1 flit/cycle while ready_i=1.
- valid_o drops to 0 after an output transfer when no input transfer occurs in the same cycle.
- Output fields are held stable while valid_o && !ready_i.
- FSM states: IDLE and LOCKED.
- IDLE:
  - Grant g is the first VC with valid_i set, searching from the RR pointer upward with wrap (NUM_VC-1 → 0). ready_o[g]=load_en.
  - On transfer of a header: go to LOCKED with owner=g.
  - On transfer of a header_tail: stay in IDLE, pointer=(g+1) mod NUM_VC.
  - On transfer of a body or tail (stray flit): the flit is accepted and discarded (not loaded, valid_o unaffected by it), error_o is set, pointer=(g+1) mod NUM_VC, state stays IDLE.
- LOCKED:
  - ready_o[owner]=load_en and all other ready_o bits are 0. Other VCs wait regardless of their valid_i.
  - body: stay in LOCKED.
  - tail: go to IDLE, pointer=(owner+1) mod NUM_VC.
  - header or header_tail arriving on the owner: error_o is set, the flit is still forwarded, and the state is unchanged.
- pkt_count_o increments by 1 on each output transfer whose flit_type_o is tail or header_tail. It wraps at 2^32.
- error_o stays set until reset.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle give back-to-back flits with no bubble.
  - A VC whose valid_i drops in mid-packet stalls the port; the lock is held.

Test Plan:
1. Single VC2 header_tail flit 0xA5, ready_i=1: ready_o=0100 at cycle 0. At cycle 1, valid_o=1, flit_o=0xA5, vc_id_o=2, flit_type_o=11. pkt_count_o=1 after the cycle-1 output transfer.
2. VC0 and VC1 each send a 3-flit packet (H,B,T) at once, ready_i=1: output order is VC0 H,B,T then VC1 H,B,T with no interleaving, 6 contiguous valid cycles, pkt_count_o=2.
3. All 4 VCs continuously send header_tail flits: vc_id_o sequence is 0,1,2,3,0,1,… (round-robin fairness). No VC is skipped.
4. ready_i=0 for 3 cycles with a flit in the output register: flit_o is held, ready_o=0000. When ready_i returns to 1, the next flit follows with no bubble and no loss.
5. A body flit on VC3 while IDLE: the flit is consumed, valid_o stays 0, and error_o=1 from the next cycle and stays 1. Then a header_tail on VC0 is ejected normally.
6. Reset asserted in the middle of a VC1 packet (after H,B): valid_o=0 and state=IDLE. The next VC2 header_tail is granted immediately from pointer 0.

Source files
------------

// File: rtl/network_ejection_vc_arbiter.sv
// Packet-level round-robin arbiter sharing one registered ejection port among NUM_VC
// virtual-channel queues; a VC that wins with a header holds the port until its tail.
module network_ejection_vc_arbiter #(
    parameter int NUM_VC      = 4,
    parameter int FLIT_WIDTH  = 64,
    parameter int VC_ID_WIDTH = $clog2(NUM_VC)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_VC*FLIT_WIDTH-1:0] flit_i,
    input  logic [NUM_VC*2-1:0]          flit_type_i,
    input  logic [NUM_VC-1:0]            valid_i,
    output logic [NUM_VC-1:0]            ready_o,
    output logic [FLIT_WIDTH-1:0]        flit_o,
    output logic [1:0]                   flit_type_o,
    output logic [VC_ID_WIDTH-1:0]       vc_id_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         error_o,
    output logic [31:0]                  pkt_count_o
);

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                  state_q;
    logic [VC_ID_WIDTH-1:0]  ptr_q, owner_q;
    logic [FLIT_WIDTH-1:0]   flit_q;
    logic [1:0]              type_q;
    logic [VC_ID_WIDTH-1:0]  vc_q;
    logic                    valid_q, error_q;
    logic [31:0]             pkt_q;

    logic                    load_en, gnt_vld, in_xfer, stray, load_flit;
    logic [VC_ID_WIDTH-1:0]  gnt, idx, next_ptr;
    logic [FLIT_WIDTH-1:0]   in_flit;
    logic [1:0]              in_type;

    assign load_en = !valid_q || ready_i;

    // Locked: the owner is the only candidate even while its valid_i is low (stall).
    always_comb begin
        gnt     = owner_q;
        gnt_vld = 1'b0;
        idx     = '0;
        if (state_q == LOCKED) begin
            gnt_vld = 1'b1;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                idx = VC_ID_WIDTH'((int'(ptr_q) + i) % NUM_VC);
                if (!gnt_vld && valid_i[idx]) begin
                    gnt     = idx;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready_o = '0;
        in_flit = '0;
        in_type = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            if (gnt == VC_ID_WIDTH'(k)) begin
                in_flit = flit_i[k*FLIT_WIDTH +: FLIT_WIDTH];
                in_type = flit_type_i[2*k +: 2];
                if (rst_ni && gnt_vld) ready_o[k] = load_en;
            end
        end
    end

    assign in_xfer   = |(valid_i & ready_o);
    assign stray     = (state_q == IDLE) && (in_type == T_BODY || in_type == T_TAIL);
    assign load_flit = in_xfer && !stray;
    assign next_ptr  = (int'(gnt) == NUM_VC - 1) ? '0 : gnt + VC_ID_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            flit_q  <= '0;
            type_q  <= '0;
            vc_q    <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            // Tail and header_tail both have bit 1 set.
            if (valid_q && ready_i && type_q[1]) pkt_q <= pkt_q + 32'd1;
            if (load_en) begin
                valid_q <= load_flit;
                if (load_flit) begin
                    flit_q <= in_flit;
                    type_q <= in_type;
                    vc_q   <= gnt;
                end
            end
            if (in_xfer) begin
                case (state_q)
                    IDLE: begin
                        case (in_type)
                            T_HEAD: begin
                                state_q <= LOCKED;
                                owner_q <= gnt;
                            end
                            T_HT:    ptr_q <= next_ptr;
                            default: begin
                                error_q <= 1'b1;
                                ptr_q   <= next_ptr;
                            end
                        endcase
                    end
                    LOCKED: begin
                        case (in_type)
                            T_TAIL: begin
                                state_q <= IDLE;
                                ptr_q   <= next_ptr;
                            end
                            T_BODY:  ;
                            default: error_q <= 1'b1;
                        endcase
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign flit_o      = flit_q;
    assign flit_type_o = type_q;
    assign vc_id_o     = vc_q;
    assign valid_o     = valid_q;
    assign error_o     = error_q;
    assign pkt_count_o = pkt_q;

endmodule
